// File: rtl/spi_flash_rd_master.sv
// -----------------------------------------------------------------------------
// spi_flash_rd_master
//
// AXI4 read-only manager for the spi_flash AXI target. One command (byte
// address + beat count) is split into INCR bursts of at most MAX_LEN beats that
// never cross a 4KB page. Read data is passed straight through to a
// valid/ready stream; done pulses at completion and err reports any bad beat.
//
// Ports
//   spi_flash_rd_aclk / spi_flash_rd_areset : clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_beats  : command handshake
//   m_ar* / m_r*                            : AXI4 AR and R channels
//   out_valid/out_data/out_last/out_ready   : read data stream to consumer
//   done / err / busy                       : completion pulse, sticky error,
//                                             activity flag
// -----------------------------------------------------------------------------
module spi_flash_rd_master #(
  parameter int DW       = 128,
  parameter int AW       = 32,
  parameter int IDW      = 8,
  parameter int ARID_VAL = 0,
  parameter int MAX_LEN  = 16,
  parameter int CNTW     = 16
) (
  input  logic            spi_flash_rd_aclk,
  input  logic            spi_flash_rd_areset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [CNTW-1:0] cmd_beats,
  output logic [IDW-1:0]  m_arid,
  output logic [AW-1:0]   m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [IDW-1:0]  m_rid,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            done,
  output logic            err,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int SZ = $clog2(BW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [8:0]      len_q, len_d;   // beats requested in the current burst
  logic [8:0]      cnt_q, cnt_d;   // beats accepted so far in the current burst
  logic            err_q, err_d;

  logic [8:0]      len_s;
  logic [8:0]      cnt_inc_s;
  logic            beat_s;
  logic            beat_bad_s;

  // Burst length: limited by remaining beats, MAX_LEN and the distance to the
  // next 4KB boundary (address is beat-aligned, so the division is exact).
  function automatic logic [8:0] burst_len(input logic [AW-1:0] a,
                                           input logic [CNTW-1:0] r);
    logic [31:0] page;
    logic [31:0] n;
    page = (32'd4096 - 32'(a[11:0])) >> SZ;
    n    = 32'(r);
    if (n > page) n = page;
    if (n > 32'(MAX_LEN)) n = 32'(MAX_LEN);
    return n[8:0];
  endfunction

  assign len_s     = burst_len(addr_q, rem_q);
  assign cnt_inc_s = cnt_q + 9'd1;
  assign beat_s    = (state_q == R) && m_rvalid && out_ready;
  // A beat is bad on error response, wrong ID, rlast at the wrong count, or
  // any beat at/after the expected last one that is not flagged rlast.
  assign beat_bad_s = (m_rresp != 2'b00) ||
                      (m_rid != IDW'(ARID_VAL)) ||
                      (m_rlast ? (cnt_inc_s != len_q) : (cnt_inc_s >= len_q));

  // State register and datapath flops.
  always_ff @(posedge spi_flash_rd_aclk or posedge spi_flash_rd_areset) begin
    if (spi_flash_rd_areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= 9'd0;
      cnt_q   <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr & ~AW'(BW - 1);
          rem_d   = cmd_beats;
          err_d   = 1'b0;
          state_d = (cmd_beats != CNTW'(0)) ? AR : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      AR: begin
        if (m_arready) begin
          addr_d  = addr_q + (AW'(len_s) << SZ);
          rem_d   = rem_q - CNTW'(len_s);
          len_d   = len_s;
          cnt_d   = 9'd0;
          state_d = R;
        end else begin
          state_d = AR;
        end
      end
      R: begin
        if (beat_s) begin
          cnt_d = cnt_inc_s;
          if (beat_bad_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (m_rlast) begin
            state_d = (rem_q == CNTW'(0)) ? DONE : AR;
          end else begin
            state_d = R;
          end
        end else begin
          state_d = R;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

  assign m_arid    = IDW'(ARID_VAL);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_s[7:0] - 8'd1;
  assign m_arsize  = 3'(SZ);
  assign m_arburst = 2'b01;
  assign m_arvalid = (state_q == AR);

  // R channel is a pure pass-through: no storage between target and consumer.
  assign m_rready  = (state_q == R) && out_ready;
  assign out_valid = (state_q == R) && m_rvalid;
  assign out_data  = m_rdata;
  assign out_last  = (state_q == R) && m_rlast && (rem_q == CNTW'(0));

endmodule

// File: tb/tb_spi_flash_rd_master.sv
module tb_spi_flash_rd_master;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IDW = 8;
  localparam int CNTW = 16;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [CNTW-1:0] cmd_beats;
  logic [IDW-1:0]  m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [IDW-1:0]  m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic            done;
  logic            err;
  logic            busy;

  spi_flash_rd_master #(.DW(DW), .AW(AW), .IDW(IDW), .ARID_VAL(0),
                        .MAX_LEN(16), .CNTW(CNTW)) dut (
    .spi_flash_rd_aclk(clk), .spi_flash_rd_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .done(done), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  typedef struct {
    logic [31:0]       addr;
    int                beats;
    int                nb;
    logic [2:0][31:0]  ar_addr;
    logic [2:0][7:0]   ar_len;
    int                err_beat;
    int                stall_after;
    logic              exp_err;
  } vec_t;

  ar_t   exp_ar[$];
  beat_t exp_q[$];
  ar_t   tq[$];

  int errors = 0;
  int checks = 0;

  int tgt_beat = 0;
  int tgt_err_beat = -1;
  int stall_after = -1;
  int stall_left = 0;
  int out_cnt = 0;

  vec_t tv[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dfn(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A1234, a + 32'd7};
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input int beats, input int nb,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2,
                              input int eb, input int sa, input logic ee);
    vec_t v;
    v.addr = addr; v.beats = beats; v.nb = nb;
    v.ar_addr[0] = a0; v.ar_len[0] = l0;
    v.ar_addr[1] = a1; v.ar_len[1] = l1;
    v.ar_addr[2] = a2; v.ar_len[2] = l2;
    v.err_beat = eb; v.stall_after = sa; v.exp_err = ee;
    return v;
  endfunction

  // AXI target model plus output monitor; drives at negedge, samples 1 unit later.
  initial begin
    int  idx;
    bit  pend;
    ar_t a;
    beat_t b;
    idx = 0; pend = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
    m_rresp = 2'b00; m_rlast = 1'b0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        tq.delete();
        idx = 0; pend = 1'b0; stall_left = 0;
        m_rvalid = 1'b0; m_arready = 1'b0; out_ready = 1'b1;
        continue;
      end
      m_arready = ($urandom_range(0, 3) != 0);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (!pend) begin
        if (tq.size() > 0 && $urandom_range(0, 4) != 0) begin
          m_rdata  = dfn(tq[0].addr + 32'(idx * 16));
          m_rlast  = (idx == int'(tq[0].len));
          m_rresp  = (tgt_beat == tgt_err_beat) ? 2'b10 : 2'b00;
          m_rid    = '0;
          m_rvalid = 1'b1;
        end else begin
          m_rvalid = 1'b0;
        end
      end
      #1;
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) begin
          chk("unexpected_ar", {96'd0, m_araddr}, {DW{1'b1}});
        end else begin
          a = exp_ar.pop_front();
          chk("ar_addr", {96'd0, m_araddr}, {96'd0, a.addr});
          chk("ar_len", {120'd0, m_arlen}, {120'd0, a.len});
        end
        chk("ar_fixed", {115'd0, m_arid, m_arsize, m_arburst}, {115'd0, 8'd0, 3'd4, 2'b01});
        tq.push_back('{addr: m_araddr, len: m_arlen});
      end
      if (m_rvalid) begin
        chk("pass_valid", {127'd0, out_valid}, {127'd0, 1'b1});
        chk("pass_data", out_data, m_rdata);
      end
      if (!out_ready) chk("stall_rready", {127'd0, m_rready}, {DW{1'b0}});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_data, {DW{1'b1}});
        end else begin
          b = exp_q.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_last", {127'd0, out_last}, {127'd0, b.last});
        end
        out_cnt++;
        if (out_cnt == stall_after) stall_left = 5;
      end
      if (m_rvalid && m_rready) begin
        pend = 1'b0;
        idx++;
        tgt_beat++;
        if (m_rlast) begin
          void'(tq.pop_front());
          idx = 0;
        end
      end else begin
        pend = m_rvalid;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    bit got;
    logic [31:0] base;
    @(negedge clk);
    tgt_beat = 0; tgt_err_beat = v.err_beat; stall_after = v.stall_after; out_cnt = 0;
    for (int i = 0; i < v.nb; i++) exp_ar.push_back('{addr: v.ar_addr[i], len: v.ar_len[i]});
    base = v.addr & ~32'd15;
    for (int i = 0; i < v.beats; i++)
      exp_q.push_back('{d: dfn(base + 32'(i * 16)), last: (i == v.beats - 1)});
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_beats = CNTW'(v.beats);
    #1 chk("cmd_ready", {127'd0, cmd_ready}, {127'd0, 1'b1});
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    chk("err_clr", {127'd0, err}, {DW{1'b0}});
    if (v.beats != 0) chk("ar_latency", {127'd0, m_arvalid}, {127'd0, 1'b1});
    else chk("done_latency0", {127'd0, done}, {127'd0, 1'b1});
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
    end
    chk("done_seen", {127'd0, got}, {127'd0, 1'b1});
    chk("err_at_done", {127'd0, err}, {127'd0, v.exp_err});
    @(negedge clk);
    #2;
    chk("done_pulse", {126'd0, done, busy}, {DW{1'b0}});
    chk("err_hold", {127'd0, err}, {127'd0, v.exp_err});
    chk("queues_empty", {64'd0, 32'(exp_ar.size()), 32'(exp_q.size())}, {DW{1'b0}});
    exp_ar.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    #1;
    chk("rst_state", {122'd0, cmd_ready, m_arvalid, out_valid, done, err, busy},
        {122'd0, 6'b100000});
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;

    tv[0] = mk(32'h1000, 1, 1, 32'h1000, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0, -1, -1, 1'b0);
    tv[1] = mk(32'h0, 40, 3, 32'h000, 8'd15, 32'h100, 8'd15, 32'h200, 8'd7, -1, -1, 1'b0);
    tv[2] = mk(32'hFC0, 8, 2, 32'hFC0, 8'd3, 32'h1000, 8'd3, 32'h0, 8'd0, -1, -1, 1'b0);
    tv[3] = mk(32'h2000, 4, 1, 32'h2000, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0, 1, -1, 1'b1);
    tv[4] = mk(32'h3000, 20, 2, 32'h3000, 8'd15, 32'h3100, 8'd3, 32'h0, 8'd0, -1, 3, 1'b0);
    tv[5] = mk(32'h4FF8, 3, 2, 32'h4FF0, 8'd0, 32'h5000, 8'd1, 32'h0, 8'd0, -1, -1, 1'b0);
    tv[6] = mk(32'h6000, 0, 0, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0, -1, -1, 1'b0);
    for (int i = 0; i < 7; i++) run_vec(tv[i]);

    // Reset in the middle of a read burst, then a zero-beat command.
    @(negedge clk);
    tgt_beat = 0; tgt_err_beat = 0; stall_after = -1; out_cnt = 0;
    exp_ar.push_back('{addr: 32'h7000, len: 8'd15});
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{d: dfn(32'h7000 + 32'(i * 16)), last: (i == 15)});
    cmd_valid = 1'b1; cmd_addr = 32'h7000; cmd_beats = 16'd16;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 500 && out_cnt < 3; i++) @(negedge clk);
    chk("rst_wait", {127'd0, out_cnt >= 3}, {127'd0, 1'b1});
    chk("err_before_rst", {127'd0, err}, {127'd0, 1'b1});
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_r", {121'd0, cmd_ready, m_arvalid, m_rready, out_valid, done, err, busy},
        {121'd0, 7'b1000000});
    exp_ar.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    run_vec(tv[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
